country_road_car_detector: RTL

Conditions the raw country-road vehicle loop sensor and produces `CAR_ON_CNTRY_RD` for `traffic_signal_control_original_synthesis`, sitting directly upstream of it. The block synchronizes and debounces the sensor and counts queued cars. It drains that count while the controller shows GREEN on the country road, and holds the request high until the queue is empty. `CNTRY_SIG` from the controller is fed back as the drain qualifier.

---
 rtl/country_road_car_detector_if.sv | 12 +
 rtl/country_road_car_detector.sv | 56 +++++
 2 files changed

// File: rtl/country_road_car_detector_if.sv
// country_road_car_detector_if: sensor/signal inputs and queue status outputs of the country-road car detector
interface country_road_car_detector_if #(
    parameter int CNT_W = 4
) ();
    logic             SENSOR_RAW;
    logic [1:0]       CNTRY_SIG;
    logic             CAR_ON_CNTRY_RD;
    logic [CNT_W-1:0] CAR_COUNT;
    logic             OVERFLOW;
    modport master (output SENSOR_RAW, CNTRY_SIG, input CAR_ON_CNTRY_RD, CAR_COUNT, OVERFLOW);
    modport slave  (input SENSOR_RAW, CNTRY_SIG, output CAR_ON_CNTRY_RD, CAR_COUNT, OVERFLOW);
endinterface

// File: rtl/country_road_car_detector.sv
// country_road_car_detector: debounced loop-sensor car queue that drives the country-road request
module country_road_car_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int MAX_CARS        = 15,
    parameter int DRAIN_CYCLES    = 3
) (
    input logic CLOCK,
    input logic CLEAR,
    country_road_car_detector_if.slave bus
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DTW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [1:0] GREEN = 2'd2;
    logic             r_s1, r_s2, r_db, r_db_q, r_ovf;
    logic [DBW-1:0]   r_dbc;
    logic [DTW-1:0]   r_dt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_arr, w_drain, w_dep, w_full, w_db_done;
    logic [CNT_W-1:0] w_cnt_nxt;
    always_comb begin
        w_arr     = r_db & ~r_db_q;
        w_drain   = (bus.CNTRY_SIG == GREEN) && (r_cnt != '0);
        w_dep     = w_drain && (r_dt == DTW'(DRAIN_CYCLES - 1));
        w_full    = r_cnt == CNT_W'(MAX_CARS);
        w_db_done = r_dbc == DBW'(DEBOUNCE_CYCLES - 1);
        // an arrival and a departure on the same edge cancel
        w_cnt_nxt = (w_arr == w_dep) ? r_cnt :
                    w_dep            ? r_cnt - CNT_W'(1) :
                    w_full           ? r_cnt : r_cnt + CNT_W'(1);
    end
    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_db   <= 1'b0;
            r_db_q <= 1'b0;
            r_dbc  <= '0;
            r_dt   <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_s1   <= bus.SENSOR_RAW;
            r_s2   <= r_s1;
            r_dbc  <= (r_s2 != r_db && !w_db_done) ? r_dbc + DBW'(1) : '0;
            r_db   <= (r_s2 != r_db && w_db_done) ? r_s2 : r_db;
            r_db_q <= r_db;
            r_dt   <= (w_drain && !w_dep) ? r_dt + DTW'(1) : '0;
            r_cnt  <= w_cnt_nxt;
            r_ovf  <= r_ovf | (w_arr & ~w_dep & w_full);
        end
    end
    assign bus.CAR_COUNT       = r_cnt;
    assign bus.CAR_ON_CNTRY_RD = r_cnt != '0;
    assign bus.OVERFLOW        = r_ovf;
endmodule
